// File: rtl/mux_rr_sched.sv
// rtl/mux_rr_sched.sv - round-robin arbitrated 8:1 mux with hold limit
// Owners are granted in PTR-relative order; every grant ends with one RELEASE cycle.
module mux_rr_sched #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] REQ,
  input  logic       DONE,
  input  logic [7:0] D,
  output logic [2:0] S,
  output logic [7:0] GNT,
  output logic       Y,
  output logic       VALID,
  output logic       BUSY,
  output logic       TOUT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] s_q, s_d;
  logic [7:0] gnt_q, gnt_d;
  logic       y_q, y_d;
  logic       valid_q, valid_d;
  logic       tout_q, tout_d;

  logic       arb_found;
  logic [2:0] arb_idx;
  logic [2:0] arb_cand;
  logic       hold_expired;
  logic       release_c;

  // First requester at or after PTR, wrapping modulo 8.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    arb_cand  = ptr_q;
    for (int k = 0; k < 8; k++) begin
      arb_cand = ptr_q + 3'(k);
      if (!arb_found && REQ[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  assign hold_expired = (cnt_q == CNT_LAST);
  assign release_c    = DONE | ~REQ[s_q] | hold_expired;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    y_d     = y_q;
    valid_d = valid_q;
    tout_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        if (arb_found) begin
          state_d = ST_GRANT;
          gnt_d   = 8'(1) << arb_idx;
          s_d     = arb_idx;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = s_q + 3'd1;
          // Timeout only when the hold limit is the sole cause.
          tout_d  = hold_expired & ~DONE & REQ[s_q];
        end else begin
          y_d     = D[s_q];
          valid_d = 1'b1;
          cnt_d   = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      gnt_q   <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end

  assign S     = s_q;
  assign GNT   = gnt_q;
  assign Y     = y_q;
  assign VALID = valid_q;
  assign BUSY  = (state_q == ST_GRANT);
  assign TOUT  = tout_q;

endmodule
